calc_key_sequencer: RTL
=======================

Name: calc_key_sequencer

Overview:
Parametrised successor to the single-digit keypad operation FSM. It takes debounced keypad codes and assembles multi-digit operands A and B in binary. It also captures the operator and drives the external memory save/recall interface. It sits between the keypad decoder and the adder/subtractor ALU, whose result feeds back in for display, save and optional chaining.

Parameters:
WIDTH, 8, operand/result/memory width in bits
MAX_DIGITS, 3, maximum decimal digits accepted per operand

Ports:
Clock  input  1  system clock; all logic on rising edge
clearIn  input  1  synchronous, active-high reset
ready  input  1  key-held level from keypad decoder; a key event is its rising edge
tecla  input  4  key code, valid while ready=1
memoryIn  input  WIDTH  recalled memory value
result  input  WIDTH  ALU result of numberA op numberB
memoryOut  output  WIDTH  value to store
signedMemory  output  1  one-cycle memory write strobe
numberA  output  WIDTH  operand A
numberB  output  WIDTH  operand B
operation  output  1  0=add, 1=sub
signedNumberA  output  1  one-cycle strobe: numberA updated
signedNumberB  output  1  one-cycle strobe: numberB updated
estate  output  2  current state code
entryOverflow  output  1  one-cycle strobe: digit rejected
clearOut  output  1  high for the cycle following reset

Behaviour:
- Key codes:
  - 0-9: digit
  - 4'b1010: CE, clear entry
  - 4'b1011: SUB
  - 4'b1100: ADD
  - 4'b1101: EQUAL
  - 4'b1110: RECOVERY
  - 4'b1111: SAVE
- Key event: evt = ready & ~ready_q, where ready_q is a registered copy of ready. Holding ready produces exactly one event. Key codes are used only on evt.
- Latency: every output updates on the clock edge after the cycle in which evt is high. All strobes are high for exactly one cycle.
- Reset (clearIn=1 at a clock edge):
  - state=S_A, digit counter=0, ready_q=0.
  - numberA, numberB, memoryOut, operation = 0.
  - All strobes = 0.
  - clearOut=1 on the next cycle, then 0.
  - Reset mid-entry discards the partial operand.
  - clearIn overrides a simultaneous evt.
- States: S_A=2'b00, S_B=2'b01, S_RES=2'b10. estate always mirrors the current state.
- Digit entry (S_A targets A, S_B targets B):
  - next = acc*10 + d, computed at WIDTH+4 bits.
  - If digitCount==MAX_DIGITS or next > 2^WIDTH-1: operand unchanged, entryOverflow pulses.
  - Otherwise: operand=next, digitCount++, and the matching signedNumberX pulses.
- CE: current operand=0, digitCount=0, signedNumberX pulses. Ignored in S_RES.
- ADD/SUB:
  - In S_A: operation=(SUB), numberB=0, digitCount=0, go to S_B.
  - In S_B: operation is replaced; B is unchanged.
  - In S_RES: see the Optional Feature.
- EQUAL: in S_B go to S_RES (B may be 0). Ignored in S_A and S_RES.
- SAVE: memoryOut = numberA (S_A), numberB (S_B) or result (S_RES); signedMemory pulses. State is unchanged.
- RECOVERY:
  - In S_A/S_B: current operand=memoryIn, digitCount=MAX_DIGITS (further digits are rejected), signedNumberX pulses.
  - In S_RES: numberA=memoryIn, numberB=0, both strobes pulse, go to S_A.
- Digit in S_RES: numberA=d, numberB=0, digitCount=1, both strobes pulse, go to S_A.
- Illegal state code 2'b11: go to S_A on the next edge, outputs held.

Optional Feature:
CALC_CHAIN_EN.
- Defined: ADD/SUB in S_RES loads numberA=result, numberB=0, sets operation, digitCount=0, pulses both strobes and goes to S_B.
- Undefined: ADD/SUB in S_RES is ignored, and the result port is used only by SAVE.

Decomposition:
- Package calc_pkg holds:
  - key-code localparams: KEY_CE, KEY_SUB, KEY_ADD, KEY_EQUAL, KEY_RECOVERY, KEY_SAVE;
  - the calc_state_t enum (S_A, S_B, S_RES);
  - an is_digit function.
- Sub-module calc_digit_accum: combinational acc*10+d, with overflow and digit-limit check, parametrised by WIDTH and MAX_DIGITS.

Test Plan:
- Reset, then keys 1,2,3 (WIDTH=8, MAX_DIGITS=3) -> numberA=123, three signedNumberA pulses, estate=00.
- Keys 2,5,6 -> numberA=25 after two digits; the third digit is rejected, so numberA stays 25 and entryOverflow pulses once.
- Keys 4,ADD,7,EQUAL -> numberA=4, numberB=7, operation=0, estate=10; then SAVE with result=11 -> memoryOut=11, one signedMemory pulse.
- ready held high for 10 cycles with tecla=5 -> exactly one digit accepted.
- Chaining, with CALC_CHAIN_EN defined: in S_RES with result=11, press SUB -> numberA=11, numberB=0, operation=1, estate=01. With the macro undefined, the same key causes no change.
- Keys 1,2 then clearIn pulsed in the same cycle as the evt for 3 -> numberA=0, estate=00, clearOut high for one cycle, key 3 not accepted.

Source files
------------

// File: rtl/calc_pkg.sv
// Key codes, state encoding and helpers shared by the calculator key sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_CE       = 4'b1010;
    localparam logic [3:0] KEY_SUB      = 4'b1011;
    localparam logic [3:0] KEY_ADD      = 4'b1100;
    localparam logic [3:0] KEY_EQUAL    = 4'b1101;
    localparam logic [3:0] KEY_RECOVERY = 4'b1110;
    localparam logic [3:0] KEY_SAVE     = 4'b1111;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_RES = 2'b10
    } calc_state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Keypad, ALU and memory signals seen by the calculator key sequencer.
interface calc_key_sequencer_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             ready;
    logic [3:0]       tecla;
    logic [WIDTH-1:0] memoryIn;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] memoryOut;
    logic             signedMemory;
    logic [WIDTH-1:0] numberA;
    logic [WIDTH-1:0] numberB;
    logic             operation;
    logic             signedNumberA;
    logic             signedNumberB;
    logic [1:0]       estate;
    logic             entryOverflow;
    logic             clearOut;

    modport master (
        input  ready, tecla, memoryIn, result,
        output memoryOut, signedMemory, numberA, numberB, operation,
               signedNumberA, signedNumberB, estate, entryOverflow, clearOut
    );

    modport slave (
        output ready, tecla, memoryIn, result,
        input  memoryOut, signedMemory, numberA, numberB, operation,
               signedNumberA, signedNumberB, estate, entryOverflow, clearOut
    );

endinterface

// File: rtl/calc_digit_accum.sv
// Combinational decimal digit append (acc*10 + digit) with range and digit-count limit checks.
module calc_digit_accum #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    input  logic [CNT_W-1:0] digitCount,
    output logic [WIDTH-1:0] nextValue,
    output logic             reject
);

    // Four extra bits hold (2^WIDTH-1)*10+9 without wrapping.
    logic [WIDTH+3:0] wide;

    always_comb begin
        wide      = ({4'b0000, acc} * (WIDTH + 4)'(10)) + {{WIDTH{1'b0}}, digit};
        nextValue = wide[WIDTH-1:0];
        reject    = (digitCount == CNT_W'(MAX_DIGITS)) || (wide > {4'b0000, {WIDTH{1'b1}}});
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad sequencer: builds decimal operands A/B, captures the operator and drives memory save.
// Define CALC_CHAIN_EN to let ADD/SUB after EQUAL chain the ALU result into operand A.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_DIGITS = 3
) (
    input logic                  Clock,
    input logic                  clearIn,
    calc_key_sequencer_if.master bus
);

    localparam int unsigned     CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    calc_state_t      stateQ, stateD;
    logic             readyQ;
    logic [CNT_W-1:0] digitCountQ, digitCountD;
    logic [WIDTH-1:0] numberAQ, numberAD;
    logic [WIDTH-1:0] numberBQ, numberBD;
    logic [WIDTH-1:0] memoryOutQ, memoryOutD;
    logic             operationQ, operationD;
    logic             sigAQ, sigAD, sigBQ, sigBD;
    logic             sigMemQ, sigMemD, ovfQ, ovfD;
    logic             clearOutQ;

    logic             evt;
    logic [3:0]       key;
    logic [WIDTH-1:0] accValue, accNext;
    logic             accReject;
    logic             opWrite;
    logic [WIDTH-1:0] opValue;

    assign evt      = bus.ready & ~readyQ;
    assign key      = bus.tecla;
    assign accValue = (stateQ == S_B) ? numberBQ : numberAQ;

    calc_digit_accum #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (CNT_W)
    ) uAccum (
        .acc        (accValue),
        .digit      (key),
        .digitCount (digitCountQ),
        .nextValue  (accNext),
        .reject     (accReject)
    );

    always_comb begin
        stateD      = stateQ;
        digitCountD = digitCountQ;
        numberAD    = numberAQ;
        numberBD    = numberBQ;
        memoryOutD  = memoryOutQ;
        operationD  = operationQ;
        sigAD       = 1'b0;
        sigBD       = 1'b0;
        sigMemD     = 1'b0;
        ovfD        = 1'b0;
        opWrite     = 1'b0;
        opValue     = '0;

        case (stateQ)
            S_A, S_B: begin
                if (evt) begin
                    if (is_digit(key)) begin
                        if (accReject) begin
                            ovfD = 1'b1;
                        end else begin
                            opWrite     = 1'b1;
                            opValue     = accNext;
                            digitCountD = digitCountQ + 1'b1;
                        end
                    end else begin
                        case (key)
                            KEY_CE: begin
                                opWrite     = 1'b1;
                                digitCountD = '0;
                            end
                            KEY_ADD, KEY_SUB: begin
                                operationD = (key == KEY_SUB);
                                if (stateQ == S_A) begin
                                    numberBD    = '0;
                                    digitCountD = '0;
                                    stateD      = S_B;
                                end
                            end
                            KEY_EQUAL: begin
                                if (stateQ == S_B) stateD = S_RES;
                            end
                            KEY_SAVE: begin
                                memoryOutD = accValue;
                                sigMemD    = 1'b1;
                            end
                            KEY_RECOVERY: begin
                                opWrite     = 1'b1;
                                opValue     = bus.memoryIn;
                                digitCountD = CNT_MAX;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_RES: begin
                if (evt) begin
                    if (is_digit(key)) begin
                        numberAD    = WIDTH'(key);
                        numberBD    = '0;
                        digitCountD = CNT_W'(1);
                        sigAD       = 1'b1;
                        sigBD       = 1'b1;
                        stateD      = S_A;
                    end else begin
                        case (key)
                            KEY_SAVE: begin
                                memoryOutD = bus.result;
                                sigMemD    = 1'b1;
                            end
                            KEY_RECOVERY: begin
                                numberAD    = bus.memoryIn;
                                numberBD    = '0;
                                digitCountD = CNT_MAX;
                                sigAD       = 1'b1;
                                sigBD       = 1'b1;
                                stateD      = S_A;
                            end
`ifdef CALC_CHAIN_EN
                            KEY_ADD, KEY_SUB: begin
                                numberAD    = bus.result;
                                numberBD    = '0;
                                operationD  = (key == KEY_SUB);
                                digitCountD = '0;
                                sigAD       = 1'b1;
                                sigBD       = 1'b1;
                                stateD      = S_B;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            // Unreachable encoding: recover to S_A, leave every output as it was.
            default: stateD = S_A;
        endcase

        if (opWrite) begin
            if (stateQ == S_A) begin
                numberAD = opValue;
                sigAD    = 1'b1;
            end else begin
                numberBD = opValue;
                sigBD    = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (clearIn) begin
            stateQ      <= S_A;
            readyQ      <= 1'b0;
            digitCountQ <= '0;
            numberAQ    <= '0;
            numberBQ    <= '0;
            memoryOutQ  <= '0;
            operationQ  <= 1'b0;
            sigAQ       <= 1'b0;
            sigBQ       <= 1'b0;
            sigMemQ     <= 1'b0;
            ovfQ        <= 1'b0;
            clearOutQ   <= 1'b1;
        end else begin
            stateQ      <= stateD;
            readyQ      <= bus.ready;
            digitCountQ <= digitCountD;
            numberAQ    <= numberAD;
            numberBQ    <= numberBD;
            memoryOutQ  <= memoryOutD;
            operationQ  <= operationD;
            sigAQ       <= sigAD;
            sigBQ       <= sigBD;
            sigMemQ     <= sigMemD;
            ovfQ        <= ovfD;
            clearOutQ   <= 1'b0;
        end
    end

    assign bus.numberA       = numberAQ;
    assign bus.numberB       = numberBQ;
    assign bus.memoryOut     = memoryOutQ;
    assign bus.operation     = operationQ;
    assign bus.signedNumberA = sigAQ;
    assign bus.signedNumberB = sigBQ;
    assign bus.signedMemory  = sigMemQ;
    assign bus.entryOverflow = ovfQ;
    assign bus.estate        = stateQ;
    assign bus.clearOut      = clearOutQ;

endmodule
